// File: rtl/spi_mnrch_burst_if.sv
// Bus bundle for the burst SPI monarch: host-side frame handshake plus the
// four SPI pins. The slave modport is the monarch's view; the master modport
// is the view of whatever sits around it (sensor logic and the SPI device).
interface spi_mnrch_burst_if #(
  parameter int WIDTH = 16
);

  logic             wrt;
  logic [WIDTH-1:0] wt_data;
  logic             hold;
  logic             MISO;
  logic             SS_n;
  logic             SCLK;
  logic             MOSI;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] rd_data;

  modport slave (
    input  wrt, wt_data, hold, MISO,
    output SS_n, SCLK, MOSI, busy, done, rd_data
  );

  modport master (
    output wrt, wt_data, hold, MISO,
    input  SS_n, SCLK, MOSI, busy, done, rd_data
  );

endinterface

// File: rtl/spi_mnrch_burst.sv
// SPI monarch, mode 3 (SCLK idles high, MOSI changes on fall, MISO sampled on
// rise), with burst support: a frame issued with hold=1 leaves SS_n low so the
// next frame continues the same transaction (auto-increment register reads).
module spi_mnrch_burst #(
  parameter int WIDTH    = 16,
  parameter int SCLK_DIV = 32
) (
  input logic              clk,
  input logic              rst_n,
  spi_mnrch_burst_if.slave bus
);

  localparam int CW = $clog2(SCLK_DIV);
  localparam int BW = $clog2(WIDTH + 1);

  // Half an SCLK period; the phase counter wraps at SCLK_DIV so both SCLK
  // edges and both porches fall out of comparing against 0 and HALF.
  localparam logic [CW-1:0] HALF     = CW'(SCLK_DIV / 2);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] FRONT = 3'd1;
  localparam logic [2:0] SHIFT = 3'd2;
  localparam logic [2:0] BACK  = 3'd3;
  localparam logic [2:0] HOLD  = 3'd4;

  logic [2:0]       state;
  logic [CW-1:0]    cnt;
  logic [BW-1:0]    bit_cnt;
  logic [WIDTH-1:0] sreg;
  logic             sample;
  logic             hold_q;
  logic             ss_n_q;
  logic             sclk_q;
  logic             done_q;
  logic             busy_q;
  logic             start;
  logic [WIDTH-1:0] shifted;

  // A new frame is only accepted while nothing is on the wire; wrt during a
  // frame is dropped so it cannot disturb the data or the hold flag.
  assign start   = bus.wrt && ((state == IDLE) || (state == HOLD));
  assign shifted = {sreg[WIDTH-2:0], sample};

  // Free-running phase counter, realigned to zero at every frame start so
  // the latency from wrt is the same whether we came from IDLE or HOLD.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // Frame sequencing: porch, SCLK generation, bit counting, shifting, and
  // the choice between releasing SS_n or parking in HOLD.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      bit_cnt <= '0;
      sreg    <= '0;
      sample  <= 1'b0;
      hold_q  <= 1'b0;
      ss_n_q  <= 1'b1;
      sclk_q  <= 1'b1;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else if (start) begin
      state   <= FRONT;
      bit_cnt <= '0;
      sreg    <= bus.wt_data;
      hold_q  <= bus.hold;
      ss_n_q  <= 1'b0;
      sclk_q  <= 1'b1;
      done_q  <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      case (state)
        FRONT: begin
          if (cnt == HALF) begin
            state  <= SHIFT;
            sclk_q <= 1'b0;
          end
        end
        SHIFT: begin
          if (sclk_q && (cnt == HALF)) begin
            sclk_q <= 1'b0;
            sreg   <= shifted;
          end else if (!sclk_q && (cnt == '0)) begin
            sclk_q  <= 1'b1;
            sample  <= bus.MISO;
            bit_cnt <= bit_cnt + BW'(1);
            if (bit_cnt == LAST_BIT) begin
              state <= BACK;
            end
          end
        end
        BACK: begin
          if (cnt == HALF) begin
            sreg   <= shifted;
            done_q <= 1'b1;
            busy_q <= 1'b0;
            if (hold_q) begin
              state <= HOLD;
            end else begin
              state  <= IDLE;
              ss_n_q <= 1'b1;
            end
          end
        end
        IDLE, HOLD: begin
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.SS_n    = ss_n_q;
  assign bus.SCLK    = sclk_q;
  assign bus.MOSI    = sreg[WIDTH-1];
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.rd_data = sreg;

endmodule

// File: tb/tb_spi_mnrch_burst.sv
// Bench for spi_mnrch_burst: a 16-bit/32-divider instance talking to a small
// inertial-sensor model (or looped back), and an 8-bit/8-divider instance in
// loopback. Table-driven single frames plus hand-written burst, hold, abort
// and ignored-wrt sequences.
module tb_spi_mnrch_burst;

  typedef struct {
    bit          sel;
    bit          loop;
    logic [15:0] data;
    logic [15:0] exp_rd;
    int          exp_lat;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic loop_big = 1'b0;
  logic sensor_miso = 1'b0;

  int n_cmp = 0;
  int n_fail = 0;
  int big_falls = 0;
  int sml_falls = 0;
  int done_rises = 0;

  int rx_cnt = 0;
  logic [7:0] cmd = 8'h00;
  logic [7:0] resp = 8'h00;

  vec_t vecs[7];

  spi_mnrch_burst_if #(.WIDTH(16)) big_if ();
  spi_mnrch_burst_if #(.WIDTH(8))  sml_if ();

  spi_mnrch_burst #(.WIDTH(16), .SCLK_DIV(32)) dut_big (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (big_if.slave)
  );

  spi_mnrch_burst #(.WIDTH(8), .SCLK_DIV(8)) dut_sml (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sml_if.slave)
  );

  assign big_if.MISO = loop_big ? big_if.MOSI : sensor_miso;
  assign sml_if.MISO = sml_if.MOSI;

  // 100 MHz system clock
  always #5 clk = ~clk;

  function automatic logic [7:0] sensorReg(input logic [7:0] c);
    return (c == 8'h8F) ? 8'h6A : (c ^ 8'h5A);
  endfunction

  // Sensor receive side: first byte is the command, the response byte is
  // looked up once it is complete; SS_n high restarts the frame.
  always @(posedge big_if.SCLK or posedge big_if.SS_n) begin
    if (big_if.SS_n) begin
      rx_cnt = 0;
    end else begin
      if (rx_cnt < 8) cmd = {cmd[6:0], big_if.MOSI};
      rx_cnt++;
      if (rx_cnt == 8) resp = sensorReg(cmd);
      if (rx_cnt == 16) rx_cnt = 0;
    end
  end

  // Sensor transmit side: zeros during the command byte, response MSB first.
  always @(negedge big_if.SCLK) begin
    if (!big_if.SS_n && rx_cnt >= 8 && rx_cnt < 16)
      sensor_miso = resp[3'(15 - rx_cnt)];
    else
      sensor_miso = 1'b0;
  end

  // Edge counters used to verify SCLK activity and done pulses per frame
  always @(negedge big_if.SCLK) big_falls++;
  always @(negedge sml_if.SCLK) sml_falls++;
  always @(posedge big_if.done) done_rises++;

  // Watchdog so the run can never hang
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, actual, expected);
    end
  endtask

  function automatic logic doneOf(input bit sel);
    return sel ? sml_if.done : big_if.done;
  endfunction

  function automatic logic ssOf(input bit sel);
    return sel ? sml_if.SS_n : big_if.SS_n;
  endfunction

  function automatic logic busyOf(input bit sel);
    return sel ? sml_if.busy : big_if.busy;
  endfunction

  function automatic logic [15:0] rdOf(input bit sel);
    return sel ? {8'h00, sml_if.rd_data} : big_if.rd_data;
  endfunction

  function automatic int fallsOf(input bit sel);
    return sel ? sml_falls : big_falls;
  endfunction

  // Present one wrt for a single clock; returns #1 after the accepting edge.
  task automatic applyStimulus(input bit sel, input logic [15:0] data, input bit hold);
    @(negedge clk);
    if (sel) begin
      sml_if.wrt = 1'b1; sml_if.wt_data = data[7:0]; sml_if.hold = hold;
    end else begin
      big_if.wrt = 1'b1; big_if.wt_data = data; big_if.hold = hold;
    end
    @(posedge clk);
    #1;
    sml_if.wrt = 1'b0;
    big_if.wrt = 1'b0;
  endtask

  // Count edges from the accepting edge until done is seen; cycles before
  // done must have SS_n low and busy high.
  task automatic waitDone(input bit sel, input int first, output int lat,
                          output int ss_bad, output int busy_bad);
    lat = -1; ss_bad = 0; busy_bad = 0;
    for (int i = first; i <= 3000; i++) begin
      @(posedge clk);
      #1;
      if (doneOf(sel) === 1'b1) begin
        lat = i;
        break;
      end
      if (ssOf(sel) !== 1'b0) ss_bad++;
      if (busyOf(sel) !== 1'b1) busy_bad++;
    end
  endtask

  initial begin
    int lat, ss_bad, busy_bad, f0, d0, gap_bad, sclk_bad, done_bad;

    big_if.wrt = 1'b0; big_if.wt_data = '0; big_if.hold = 1'b0;
    sml_if.wrt = 1'b0; sml_if.wt_data = '0; sml_if.hold = 1'b0;

    vecs[0] = '{sel: 1'b0, loop: 1'b0, data: 16'h8F00, exp_rd: 16'h006A, exp_lat: 529};
    vecs[1] = '{sel: 1'b0, loop: 1'b1, data: 16'h1234, exp_rd: 16'h1234, exp_lat: 529};
    vecs[2] = '{sel: 1'b1, loop: 1'b1, data: 16'h00A5, exp_rd: 16'h00A5, exp_lat: 69};
    vecs[3] = '{sel: 1'b1, loop: 1'b1, data: 16'h003C, exp_rd: 16'h003C, exp_lat: 69};
    vecs[4] = '{sel: 1'b1, loop: 1'b1, data: 16'h0081, exp_rd: 16'h0081, exp_lat: 69};
    vecs[5] = '{sel: 1'b0, loop: 1'b1, data: 16'h8001, exp_rd: 16'h8001, exp_lat: 529};
    vecs[6] = '{sel: 1'b0, loop: 1'b0, data: 16'h8A00, exp_rd: 16'h00D0, exp_lat: 529};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset SS_n", big_if.SS_n, 1'b1);
    checkOutput("reset SCLK", big_if.SCLK, 1'b1);
    checkOutput("reset done", big_if.done, 1'b0);
    checkOutput("reset busy", big_if.busy, 1'b0);
    checkOutput("reset rd_data", big_if.rd_data, 16'h0000);
    checkOutput("reset MOSI", big_if.MOSI, 1'b0);
    checkOutput("reset sml SS_n", sml_if.SS_n, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Single frames from the table
    for (int v = 0; v < 7; v++) begin
      loop_big = vecs[v].loop;
      f0 = fallsOf(vecs[v].sel);
      applyStimulus(vecs[v].sel, vecs[v].data, 1'b0);
      checkOutput($sformatf("v%0d SS_n after wrt", v), ssOf(vecs[v].sel), 1'b0);
      waitDone(vecs[v].sel, 1, lat, ss_bad, busy_bad);
      checkOutput($sformatf("v%0d latency", v), lat, vecs[v].exp_lat);
      checkOutput($sformatf("v%0d rd_data", v), rdOf(vecs[v].sel), vecs[v].exp_rd);
      checkOutput($sformatf("v%0d SCLK falls", v), fallsOf(vecs[v].sel) - f0,
                  vecs[v].sel ? 8 : 16);
      checkOutput($sformatf("v%0d SS_n early rise", v), ss_bad, 0);
      checkOutput($sformatf("v%0d busy gaps", v), busy_bad, 0);
      checkOutput($sformatf("v%0d SS_n at done", v), ssOf(vecs[v].sel), 1'b1);
      checkOutput($sformatf("v%0d busy at done", v), busyOf(vecs[v].sel), 1'b0);
      repeat (4) @(posedge clk);
    end

    // wrt with different data and hold=1 pulsed mid-frame must be ignored
    loop_big = 1'b1;
    applyStimulus(1'b0, 16'h1234, 1'b0);
    repeat (99) @(posedge clk);
    @(negedge clk);
    big_if.wrt = 1'b1; big_if.wt_data = 16'hFFFF; big_if.hold = 1'b1;
    @(posedge clk);
    #1;
    big_if.wrt = 1'b0; big_if.hold = 1'b0;
    waitDone(1'b0, 101, lat, ss_bad, busy_bad);
    checkOutput("ignored wrt latency", lat, 529);
    checkOutput("ignored wrt rd_data", big_if.rd_data, 16'h1234);
    checkOutput("ignored wrt hold not latched", big_if.SS_n, 1'b1);
    repeat (4) @(posedge clk);

    // Synchronous reset in the middle of SHIFT, then a clean frame
    applyStimulus(1'b0, 16'hBEEF, 1'b0);
    repeat (100) @(posedge clk);
    #1;
    checkOutput("pre-abort busy", big_if.busy, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("abort SS_n", big_if.SS_n, 1'b1);
    checkOutput("abort SCLK", big_if.SCLK, 1'b1);
    checkOutput("abort done", big_if.done, 1'b0);
    checkOutput("abort busy", big_if.busy, 1'b0);
    checkOutput("abort rd_data", big_if.rd_data, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    applyStimulus(1'b0, 16'hC3A5, 1'b0);
    waitDone(1'b0, 1, lat, ss_bad, busy_bad);
    checkOutput("post-abort latency", lat, 529);
    checkOutput("post-abort rd_data", big_if.rd_data, 16'hC3A5);
    repeat (4) @(posedge clk);

    // Burst: two sensor reads with SS_n held low between them
    loop_big = 1'b0;
    d0 = done_rises;
    applyStimulus(1'b0, 16'hA600, 1'b1);
    waitDone(1'b0, 1, lat, ss_bad, busy_bad);
    checkOutput("burst1 latency", lat, 529);
    checkOutput("burst1 rd_data", big_if.rd_data, 16'h00FC);
    checkOutput("burst1 SS_n at done", big_if.SS_n, 1'b0);
    gap_bad = ss_bad;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      if (big_if.SS_n !== 1'b0) gap_bad++;
    end
    applyStimulus(1'b0, 16'hA700, 1'b0);
    if (big_if.SS_n !== 1'b0) gap_bad++;
    waitDone(1'b0, 1, lat, ss_bad, busy_bad);
    gap_bad += ss_bad;
    checkOutput("burst2 latency", lat, 529);
    checkOutput("burst2 rd_data", big_if.rd_data, 16'h00FD);
    checkOutput("burst SS_n continuous", gap_bad, 0);
    checkOutput("burst done count", done_rises - d0, 2);
    checkOutput("burst2 SS_n rises with done", big_if.SS_n, 1'b1);
    repeat (4) @(posedge clk);

    // Long park in HOLD, then close the burst
    applyStimulus(1'b0, 16'hA600, 1'b1);
    waitDone(1'b0, 1, lat, ss_bad, busy_bad);
    checkOutput("hold frame latency", lat, 529);
    gap_bad = 0; sclk_bad = 0; done_bad = 0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk);
      #1;
      if (big_if.SS_n !== 1'b0) gap_bad++;
      if (big_if.SCLK !== 1'b1) sclk_bad++;
      if (big_if.done !== 1'b1) done_bad++;
    end
    checkOutput("hold SS_n low", gap_bad, 0);
    checkOutput("hold SCLK idle", sclk_bad, 0);
    checkOutput("hold done kept", done_bad, 0);
    applyStimulus(1'b0, 16'hA700, 1'b0);
    checkOutput("close done cleared", big_if.done, 1'b0);
    waitDone(1'b0, 1, lat, ss_bad, busy_bad);
    checkOutput("close latency", lat, 529);
    checkOutput("close rd_data", big_if.rd_data, 16'h00FD);
    checkOutput("close SS_n", big_if.SS_n, 1'b1);

    repeat (4) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
